// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment message arbiter.
package sev_seg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ID_W   = 2;

  localparam int unsigned REQ_ERR    = 0;
  localparam int unsigned REQ_PROMPT = 1;
  localparam int unsigned REQ_INFO   = 2;

  localparam logic [DIGITS-1:0] DIGITS_ON  = 8'hFF;
  localparam logic [DIGITS-1:0] DIGITS_OFF = 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  // Blank phase high means every digit is switched off.
  function automatic logic [DIGITS-1:0] digit_mask(input logic blank);
    return blank ? DIGITS_OFF : DIGITS_ON;
  endfunction

endpackage

// File: rtl/sev_seg_blink_gen.sv
// Tick-driven reloadable down-counter with a phase toggle on every wrap.
// Used both for the blink half-period and for the message hold interval.
module sev_seg_blink_gen
  import sev_seg_pkg::*;
#(
  parameter int unsigned PERIOD = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  input  logic enable,
  output logic blank,
  output logic wrap_c
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blank_q, blank_d;

  // Wrap fires on the tick that finds the counter already at zero.
  assign wrap_c = !load && enable && tick && (cnt_q == '0);
  assign blank  = blank_q;

  always_comb begin
    cnt_d   = cnt_q;
    blank_d = blank_q;
    if (load) begin
      cnt_d   = RELOAD;
      blank_d = 1'b0;
    end else if (wrap_c) begin
      cnt_d   = RELOAD;
      blank_d = ~blank_q;
    end else if (enable && tick) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
    end
  end

endmodule

// File: rtl/sev_seg_msg_arbiter.sv
// Fixed-priority arbiter that shows one requester's word for a timed hold,
// optionally blinking, then falls back to the background word.
module sev_seg_msg_arbiter
  import sev_seg_pkg::*;
#(
  parameter int unsigned HOLD_MS  = 2000,
  parameter int unsigned BLINK_MS = 250,
  parameter int unsigned NUM_REQ  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_1ms,
  input  logic [DATA_W-1:0]         base_data,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [DATA_W*NUM_REQ-1:0] msg_data,
  input  logic [NUM_REQ-1:0]        msg_blink,
  input  logic                      abort,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic [ID_W-1:0]           active_id,
  output logic [DATA_W-1:0]         disp_data,
  output logic [DIGITS-1:0]         digit_en
);

  if (HOLD_MS < 1 || HOLD_MS > 65535) begin : g_bad_hold
    $error("HOLD_MS out of range 1..65535");
  end
  if (BLINK_MS < 1 || BLINK_MS > 65535) begin : g_bad_blink
    $error("BLINK_MS out of range 1..65535");
  end
  if (NUM_REQ != 3) begin : g_bad_nreq
    $error("NUM_REQ must be 3");
  end

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     active_id_q, active_id_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                blink_flag_q, blink_flag_d;

  logic                req_any_c;
  logic [ID_W-1:0]     grant_id_c;
  logic [DATA_W-1:0]   grant_word_c;
  logic                grant_blink_c;
  logic                load_c;
  logic                show_c;
  logic                hold_wrap_c;
  logic                hold_phase_unused;
  logic                blink_wrap_c;
  logic                blink_blank;

  // Lowest requesting index wins; scanning downward lets it overwrite.
  always_comb begin
    req_any_c     = |req;
    grant_id_c    = '0;
    grant_word_c  = '0;
    grant_blink_c = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_id_c    = ID_W'(i);
        grant_word_c  = msg_data[i*DATA_W +: DATA_W];
        grant_blink_c = msg_blink[i];
      end
    end
  end

  assign show_c = (state_q == SHOW);

  sev_seg_blink_gen #(
    .PERIOD (HOLD_MS)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .tick   (tick_1ms),
    .enable (show_c),
    .blank  (hold_phase_unused),
    .wrap_c (hold_wrap_c)
  );

  sev_seg_blink_gen #(
    .PERIOD (BLINK_MS)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .tick   (tick_1ms),
    .enable (show_c && blink_flag_q),
    .blank  (blink_blank),
    .wrap_c (blink_wrap_c)
  );

  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    done_d       = '0;
    busy_d       = busy_q;
    active_id_d  = active_id_q;
    disp_data_d  = disp_data_q;
    digit_en_d   = digit_en_q;
    blink_flag_d = blink_flag_q;
    load_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        disp_data_d = base_data;
        digit_en_d  = DIGITS_ON;
        busy_d      = 1'b0;
        active_id_d = '0;
        if (req_any_c) begin
          state_d      = SHOW;
          load_c       = 1'b1;
          ack_d        = NUM_REQ'(1) << grant_id_c;
          active_id_d  = grant_id_c;
          busy_d       = 1'b1;
          disp_data_d  = grant_word_c;
          blink_flag_d = grant_blink_c;
        end
      end
      SHOW: begin
        // Abort outranks a coinciding expiry, so it never yields done.
        if (abort || hold_wrap_c) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          active_id_d = '0;
          disp_data_d = base_data;
          digit_en_d  = DIGITS_ON;
          if (!abort) begin
            done_d = NUM_REQ'(1) << active_id_q;
          end
        end else if (blink_flag_q) begin
          digit_en_d = digit_mask(blink_blank ^ blink_wrap_c);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ack_q        <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      active_id_q  <= '0;
      disp_data_q  <= '0;
      digit_en_q   <= DIGITS_ON;
      blink_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      active_id_q  <= active_id_d;
      disp_data_q  <= disp_data_d;
      digit_en_q   <= digit_en_d;
      blink_flag_q <= blink_flag_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;
  assign disp_data = disp_data_q;
  assign digit_en  = digit_en_q;

endmodule

// File: tb/tb_sev_seg_msg_arbiter.sv
// Scoreboard bench for sev_seg_msg_arbiter with a short hold and blink period.
module tb_sev_seg_msg_arbiter;

  localparam int unsigned HOLD  = 5;
  localparam int unsigned BLINK = 2;

  localparam logic [31:0] W0 = 32'h2222_2222;
  localparam logic [31:0] W1 = 32'h1111_1111;
  localparam logic [31:0] W2 = 32'hAAAA_AAAA;

  typedef logic [48:0] vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1ms;
  logic [31:0] base_data;
  logic [2:0]  req;
  logic [95:0] msg_data;
  logic [2:0]  msg_blink;
  logic        abort;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic        busy;
  logic [1:0]  active_id;
  logic [31:0] disp_data;
  logic [7:0]  digit_en;

  vec_t exp_q[$];
  vec_t e_v;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sev_seg_msg_arbiter #(
    .HOLD_MS  (HOLD),
    .BLINK_MS (BLINK),
    .NUM_REQ  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1ms  (tick_1ms),
    .base_data (base_data),
    .req       (req),
    .msg_data  (msg_data),
    .msg_blink (msg_blink),
    .abort     (abort),
    .ack       (ack),
    .done      (done),
    .busy      (busy),
    .active_id (active_id),
    .disp_data (disp_data),
    .digit_en  (digit_en)
  );

  function automatic vec_t pk(input logic [2:0] a, input logic [2:0] d, input logic b,
                              input logic [1:0] id, input logic [31:0] w, input logic [7:0] en);
    return {a, d, b, id, w, en};
  endfunction

  function automatic vec_t obs();
    return {ack, done, busy, active_id, disp_data, digit_en};
  endfunction

  // Expected outputs after the k-th counted tick of a message shown from requester id.
  function automatic vec_t hold_exp(input int id, input logic [31:0] word, input logic blk,
                                    input int k, input logic [31:0] base);
    if (k >= int'(HOLD)) return pk(3'b000, 3'(1 << id), 1'b0, 2'b00, base, 8'hFF);
    return pk(3'b000, 3'b000, 1'b1, 2'(id), word,
              (blk && ((k / int'(BLINK)) % 2 == 1)) ? 8'h00 : 8'hFF);
  endfunction

  task automatic test_reset();
    string nm;
    nm = "reset_vals";
    exp_q.push_back(pk(3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 8'hFF));
    @(posedge clk); @(posedge clk); #1;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    rst = 1'b0;
    nm = "idle_base";
    exp_q.push_back(pk(3'b000, 3'b000, 1'b0, 2'b00, 32'h0000_1234, 8'hFF));
    @(posedge clk); #1;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
  endtask

  task automatic test_priority();
    string nm;
    msg_data  = {W2, W1, W0};
    msg_blink = 3'b000;
    req       = 3'b110;
    nm = "grant_prio";
    exp_q.push_back(pk(3'b010, 3'b000, 1'b1, 2'd1, W1, 8'hFF));
    @(posedge clk); #1;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    req = 3'b100;
    for (int k = 1; k <= int'(HOLD); k++) begin
      tick_1ms = 1'b1;
      nm = (k == int'(HOLD)) ? "hold_done" : "hold_tick";
      exp_q.push_back(hold_exp(1, W1, 1'b0, k, base_data));
      @(posedge clk); #1;
      tick_1ms = 1'b0;
      e_v = exp_q.pop_front(); n_chk++;
      if (obs() !== e_v) $display("FAIL %s k=%0d: got %h expected %h", nm, k, obs(), e_v); else n_pass++;
      if (k < int'(HOLD)) begin
        nm = "hold_gap";
        exp_q.push_back(hold_exp(1, W1, 1'b0, k, base_data));
        @(posedge clk); #1;
        e_v = exp_q.pop_front(); n_chk++;
        if (obs() !== e_v) $display("FAIL %s k=%0d: got %h expected %h", nm, k, obs(), e_v); else n_pass++;
      end
    end
    nm = "pending_grant";
    exp_q.push_back(pk(3'b100, 3'b000, 1'b1, 2'd2, W2, 8'hFF));
    @(posedge clk); #1;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
  endtask

  task automatic test_blink_no_preempt();
    string nm;
    // Higher-priority request and blink flag change mid-show must not disturb message 2.
    req       = 3'b001;
    msg_blink = 3'b001;
    for (int k = 1; k <= int'(HOLD); k++) begin
      tick_1ms = 1'b1;
      nm = "no_preempt";
      exp_q.push_back(hold_exp(2, W2, 1'b0, k, base_data));
      @(posedge clk); #1;
      tick_1ms = 1'b0;
      e_v = exp_q.pop_front(); n_chk++;
      if (obs() !== e_v) $display("FAIL %s k=%0d: got %h expected %h", nm, k, obs(), e_v); else n_pass++;
    end
    nm = "grant_after_done";
    exp_q.push_back(pk(3'b001, 3'b000, 1'b1, 2'd0, W0, 8'hFF));
    @(posedge clk); #1;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    req = 3'b000;
    for (int k = 1; k <= int'(HOLD); k++) begin
      tick_1ms = 1'b1;
      nm = "blink_tick";
      exp_q.push_back(hold_exp(0, W0, 1'b1, k, base_data));
      @(posedge clk); #1;
      tick_1ms = 1'b0;
      e_v = exp_q.pop_front(); n_chk++;
      if (obs() !== e_v) $display("FAIL %s k=%0d: got %h expected %h", nm, k, obs(), e_v); else n_pass++;
      nm = (k < int'(HOLD)) ? "blink_gap" : "idle_after_blink";
      exp_q.push_back((k < int'(HOLD)) ? hold_exp(0, W0, 1'b1, k, base_data)
                                       : pk(3'b000, 3'b000, 1'b0, 2'b00, base_data, 8'hFF));
      @(posedge clk); #1;
      e_v = exp_q.pop_front(); n_chk++;
      if (obs() !== e_v) $display("FAIL %s k=%0d: got %h expected %h", nm, k, obs(), e_v); else n_pass++;
    end
  endtask

  task automatic test_abort();
    string nm;
    base_data = 32'h0000_5678;
    msg_blink = 3'b000;
    abort     = 1'b1;
    nm = "abort_idle";
    exp_q.push_back(pk(3'b000, 3'b000, 1'b0, 2'b00, 32'h0000_5678, 8'hFF));
    @(posedge clk); #1;
    abort = 1'b0;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    req = 3'b010;
    nm = "abort_grant";
    exp_q.push_back(pk(3'b010, 3'b000, 1'b1, 2'd1, W1, 8'hFF));
    @(posedge clk); #1;
    req = 3'b000;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    for (int k = 1; k <= 2; k++) begin
      tick_1ms = 1'b1;
      nm = "pre_abort_tick";
      exp_q.push_back(hold_exp(1, W1, 1'b0, k, base_data));
      @(posedge clk); #1;
      tick_1ms = 1'b0;
      e_v = exp_q.pop_front(); n_chk++;
      if (obs() !== e_v) $display("FAIL %s k=%0d: got %h expected %h", nm, k, obs(), e_v); else n_pass++;
    end
    abort = 1'b1;
    nm = "abort_show";
    exp_q.push_back(pk(3'b000, 3'b000, 1'b0, 2'b00, 32'h0000_5678, 8'hFF));
    @(posedge clk); #1;
    abort = 1'b0;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    nm = "abort_no_done";
    exp_q.push_back(pk(3'b000, 3'b000, 1'b0, 2'b00, 32'h0000_5678, 8'hFF));
    @(posedge clk); #1;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    req       = 3'b001;
    msg_blink = 3'b001;
    nm = "abort2_grant";
    exp_q.push_back(pk(3'b001, 3'b000, 1'b1, 2'd0, W0, 8'hFF));
    @(posedge clk); #1;
    req = 3'b000;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    for (int k = 1; k < int'(HOLD); k++) begin
      tick_1ms = 1'b1;
      nm = "abort2_tick";
      exp_q.push_back(hold_exp(0, W0, 1'b1, k, base_data));
      @(posedge clk); #1;
      tick_1ms = 1'b0;
      e_v = exp_q.pop_front(); n_chk++;
      if (obs() !== e_v) $display("FAIL %s k=%0d: got %h expected %h", nm, k, obs(), e_v); else n_pass++;
    end
    tick_1ms = 1'b1;
    abort    = 1'b1;
    nm = "abort_final_tick";
    exp_q.push_back(pk(3'b000, 3'b000, 1'b0, 2'b00, 32'h0000_5678, 8'hFF));
    @(posedge clk); #1;
    tick_1ms = 1'b0;
    abort    = 1'b0;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    nm = "abort_final_idle";
    exp_q.push_back(pk(3'b000, 3'b000, 1'b0, 2'b00, 32'h0000_5678, 8'hFF));
    @(posedge clk); #1;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
  endtask

  task automatic test_reset_mid_show();
    string nm;
    msg_blink = 3'b100;
    req       = 3'b100;
    nm = "rst_pre_grant";
    exp_q.push_back(pk(3'b100, 3'b000, 1'b1, 2'd2, W2, 8'hFF));
    @(posedge clk); #1;
    req      = 3'b010;
    rst      = 1'b1;
    tick_1ms = 1'b1;
    for (int c = 0; c < 2; c++) begin
      nm = "rst_mid_show";
      exp_q.push_back(pk(3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 8'hFF));
    end
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", "rst_pre_grant", obs(), e_v); else n_pass++;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      tick_1ms = 1'b0;
      e_v = exp_q.pop_front(); n_chk++;
      if (obs() !== e_v) $display("FAIL %s c=%0d: got %h expected %h", nm, c, obs(), e_v); else n_pass++;
    end
    rst = 1'b0;
    nm = "rst_regrant";
    exp_q.push_back(pk(3'b010, 3'b000, 1'b1, 2'd1, W1, 8'hFF));
    @(posedge clk); #1;
    req = 3'b000;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
    for (int k = 1; k <= int'(HOLD); k++) begin
      tick_1ms = 1'b1;
      nm = "rst_full_hold";
      exp_q.push_back(hold_exp(1, W1, 1'b0, k, base_data));
      @(posedge clk); #1;
      tick_1ms = 1'b0;
      e_v = exp_q.pop_front(); n_chk++;
      if (obs() !== e_v) $display("FAIL %s k=%0d: got %h expected %h", nm, k, obs(), e_v); else n_pass++;
    end
    nm = "done_single_cycle";
    exp_q.push_back(pk(3'b000, 3'b000, 1'b0, 2'b00, base_data, 8'hFF));
    @(posedge clk); #1;
    e_v = exp_q.pop_front(); n_chk++;
    if (obs() !== e_v) $display("FAIL %s: got %h expected %h", nm, obs(), e_v); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    tick_1ms  = 1'b0;
    abort     = 1'b0;
    req       = 3'b000;
    msg_blink = 3'b000;
    msg_data  = '0;
    base_data = 32'h0000_1234;
    test_reset();
    test_priority();
    test_blink_no_preempt();
    test_abort();
    test_reset_mid_show();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sev_seg_msg_arbiter.md
# sev_seg_msg_arbiter

Arbiter and sequencer for the eight-digit seven-segment display. It shares the single 32-bit display data word between three message requesters (0 = error, 1 = prompt, 2 = info) and a background word such as the account balance. Each granted message is held for a timed interval with optional blinking, and the display falls back to the background word when the interval ends. Its outputs drive the existing seven-segment display datapath (data word plus per-digit enables).

## Interface
Parameters:
- HOLD_MS, 2000: message display time in 1 ms ticks; legal range 1..65535.
- BLINK_MS, 250: blink half-period in ticks; legal range 1..65535.
- NUM_REQ, 3: number of requesters; fixed at 3 for this revision.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- tick_1ms  in  1  one-cycle enable strobe, once per ms
- base_data  in  32  background word, 8 BCD nibbles
- req  in  3  request level per requester; held until ack
- msg_data  in  96  packed message words; requester i uses bits [32i+31:32i]
- msg_blink  in  3  blink request per requester; sampled at grant
- abort  in  1  one-cycle pulse; clears the active message immediately
- ack  out  3  one-hot, one-cycle grant pulse
- done  out  3  one-hot, one-cycle pulse at normal hold expiry
- busy  out  1  high while a message is shown
- active_id  out  2  index of the current message; 0 when idle
- disp_data  out  32  word to the display datapath
- digit_en  out  8  per-digit enable; 0 = digit blanked

## Operation
- The block has two states: IDLE and SHOW. All outputs are registered.
- **IDLE:**
  - disp_data <= base_data every cycle, giving one cycle of latency.
  - digit_en = 8'hFF and busy = 0.
  - If any req bit is high, grant the lowest index (fixed priority; 0 is highest).
  - On the grant edge:
    - latch msg_data[i] into disp_data and latch msg_blink[i];
    - set ack[i] = 1, active_id = i and busy = 1;
    - load hold_cnt = HOLD_MS-1 and blink_cnt = BLINK_MS-1, with blank phase = 0.
  - Then go to SHOW.
- **SHOW:**
  - disp_data stays frozen, and later req changes are ignored (no preemption).
  - On each tick_1ms:
    - if hold_cnt == 0: go to IDLE, pulse done[active_id], set busy = 0 and digit_en = FF, and load disp_data <= base_data;
    - otherwise decrement hold_cnt.
  - Blink, when the latched flag is set:
    - on each tick, if blink_cnt == 0, toggle the blank phase and reload BLINK_MS-1; otherwise decrement;
    - digit_en = blank ? 8'h00 : 8'hFF.
  - With the blink flag clear, digit_en stays FF.
  - abort in SHOW: go to IDLE on the next edge with no done pulse, set busy = 0 and digit_en = FF, and load disp_data <= base_data. abort in IDLE has no effect.
- Simultaneous events:
  - abort and expiry on the same tick: abort wins, so no done pulse.
  - Requests are never granted in the same cycle that SHOW exits. The earliest re-grant is the edge after IDLE is entered, so ack pulses are at least 2 cycles apart.
  - After a grant the requester must drop req. A req still high on the following IDLE cycle is treated as a new request.

## Timing
- Reset values: state IDLE, disp_data = 0, digit_en = 8'hFF, ack = 0, done = 0, busy = 0, active_id = 0, counters 0, blank phase 0.
- A reset mid-SHOW behaves exactly the same; no done pulse is produced.
- Grant latency: req is sampled high in IDLE cycle t, and ack plus the new disp_data appear in cycle t+1.
- Hold: a message is shown for exactly HOLD_MS tick_1ms strobes counted after the grant. done goes high in the cycle after the HOLD_MS-th tick.
- Blink: the first blank phase starts after BLINK_MS ticks, then toggles every BLINK_MS ticks.
- tick_1ms arriving in the grant cycle itself is not counted.

## Structure
- Package sev_seg_pkg holds:
  - the state enum (IDLE, SHOW);
  - REQ_ERR = 0, REQ_PROMPT = 1, REQ_INFO = 2;
  - DIGITS_ON = 8'hFF and DIGITS_OFF = 8'h00.
- One sub-module, sev_seg_blink_gen, covers the tick-driven reloadable down-counter and phase toggle.
  - Ports: clk, rst, load, tick, enable; output blank.
  - It is reused for the hold counter with its toggle output unused.
- The priority encoder and state register stay in the top level.

## Test plan
- Run with HOLD_MS = 5 and BLINK_MS = 2.
- After reset, check disp_data = 0, then drive base_data = 32'h0000_1234 → disp_data = 32'h0000_1234 one cycle later, digit_en = FF, busy = 0.
- Assert req = 3'b110 with msg_data words 2 = 32'hAAAA_AAAA and 1 = 32'h1111_1111 → ack = 3'b010, disp_data = 32'h1111_1111, active_id = 1.
- Hold the message and deliver 5 ticks → done = 3'b010 in the cycle after the 5th tick, then disp_data returns to base_data. A pending req[2] gets ack one cycle after that.
- Grant with msg_blink[0] = 1 → digit_en goes FF, 00 (after tick 2), FF (after tick 4), then FF at expiry.
- abort in SHOW → IDLE next edge, no done, busy = 0. abort together with the final tick also gives no done.
- rst pulse mid-SHOW → all outputs return to their reset values. A req held high during reset is granted on the first edge after reset deasserts.
